// File: rtl/pulse_handshake_tx_if.sv
// rtl/pulse_handshake_tx_if.sv - handshake/status bundle for pulse_handshake_tx
// master: transmitter side (drives req_out and status); slave: far end / stimulus side.
interface pulse_handshake_tx_if #(
  parameter int CNT_W = 3
);
  logic             pulse_in;
  logic             ack_async;
  logic             req_out;
  logic             busy;
  logic [CNT_W-1:0] pending;
  logic             overflow;
  logic             timeout;

  modport master (
    input  pulse_in,
    input  ack_async,
    output req_out,
    output busy,
    output pending,
    output overflow,
    output timeout
  );

  modport slave (
    output pulse_in,
    output ack_async,
    input  req_out,
    input  busy,
    input  pending,
    input  overflow,
    input  timeout
  );
endinterface

// File: rtl/pulse_handshake_tx.sv
// rtl/pulse_handshake_tx.sv - pulse to four-phase request/ack transmitter with request queueing
// Optional per-phase watchdog enabled by macro PULSE_TX_TIMEOUT_EN.
module pulse_handshake_tx #(
  parameter int CNT_W       = 3,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  nrst,
  pulse_handshake_tx_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic             req_q;
  logic             ack_meta_q, ack_s_q;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic             advance;
  logic             launch;
  logic             abort;

  // Two-flop synchronizer for the far-domain acknowledge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= bus.ack_async;
      ack_s_q    <= ack_meta_q;
    end
  end

  always_comb begin
    advance = 1'b0;
    case (state_q)
      IDLE:    advance = (pending_q != '0) || bus.pulse_in;
      REQ_HI:  advance = ack_s_q;
      REQ_LO:  advance = !ack_s_q;
      default: advance = 1'b1;
    endcase
  end

  assign launch = (state_q == IDLE) && advance;

`ifdef PULSE_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] phase_cnt_q;
  logic          timeout_q;

  assign abort = (state_q != IDLE) && !advance && (phase_cnt_q == TW'(TIMEOUT_CYC - 1));

  // Counter restarts on every state change, so entry to either phase sees zero.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      phase_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        phase_cnt_q <= '0;
      end else if (state_q != IDLE) begin
        phase_cnt_q <= phase_cnt_q + 1'b1;
      end
      if (abort) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign abort       = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // State register; req_q is registered from the next state so req_out never glitches.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= (state_d == REQ_HI);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (advance) state_d = REQ_HI;
      REQ_HI:  if (advance) state_d = REQ_LO;
               else if (abort) state_d = IDLE;
      REQ_LO:  if (advance || abort) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_out  = req_q;
    bus.busy     = (state_q != IDLE);
    bus.pending  = pending_q;
    bus.overflow = overflow_q;
  end

  // A launch drains the queue first; a pulse the launch did not absorb is queued.
  always_comb begin
    logic take_pend;
    logic queue_pulse;
    pending_d   = pending_q;
    overflow_d  = overflow_q;
    take_pend   = launch && (pending_q != '0);
    queue_pulse = bus.pulse_in && !(launch && (pending_q == '0));
    if (take_pend && !queue_pulse) begin
      pending_d = pending_q - 1'b1;
    end else if (queue_pulse && !take_pend) begin
      if (pending_q == PEND_MAX) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// tb/tb_pulse_handshake_tx.sv - directed self-checking bench for pulse_handshake_tx
module tb_pulse_handshake_tx;

  logic clk;
  logic nrst;
  int   n_checks;
  int   n_pass;

  pulse_handshake_tx_if #(.CNT_W(3)) bus ();

  pulse_handshake_tx #(.CNT_W(3), .TIMEOUT_CYC(16)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    nrst          = 1'b0;
    bus.pulse_in  = 1'b0;
    bus.ack_async = 1'b0;
    step(2);
    check("rst_req", bus.req_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_pend", bus.pending, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_tmo", bus.timeout, 0);
    nrst = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // Single transfer with ack 3 cycles after req and release 3 cycles after req falls.
    do_reset();
    bus.pulse_in = 1'b1;
    step(1);
    bus.pulse_in = 1'b0;
    check("t1_req_edge1", bus.req_out, 1);
    check("t1_busy", bus.busy, 1);
    check("t1_pend", bus.pending, 0);
    step(3);
    bus.ack_async = 1'b1;
    step(2);
    check("t1_req_sync_lag", bus.req_out, 1);
    step(1);
    check("t1_req_fall", bus.req_out, 0);
    check("t1_busy_lo", bus.busy, 1);
    step(3);
    bus.ack_async = 1'b0;
    step(2);
    check("t1_busy_lag", bus.busy, 1);
    step(1);
    check("t1_idle", bus.busy, 0);
    check("t1_pend_end", bus.pending, 0);

    // ack high while idle must be ignored.
    bus.ack_async = 1'b1;
    step(4);
    check("t_ack_idle_busy", bus.busy, 0);
    check("t_ack_idle_req", bus.req_out, 0);
    bus.ack_async = 1'b0;
    step(3);

    // Five consecutive pulses, ack stuck low.
    do_reset();
    bus.pulse_in = 1'b1;
    step(5);
    bus.pulse_in = 1'b0;
    check("t2_pend4", bus.pending, 4);
    check("t2_req", bus.req_out, 1);
    check("t2_ovf", bus.overflow, 0);

    // Saturation: 8 pulses fill to 7 without overflow, the 9th overflows.
    do_reset();
    bus.pulse_in = 1'b1;
    step(8);
    check("t3_pend_sat", bus.pending, 7);
    check("t3_no_ovf_yet", bus.overflow, 0);
    step(1);
    bus.pulse_in = 1'b0;
    check("t3_pend_hold", bus.pending, 7);
    check("t3_ovf", bus.overflow, 1);
    step(5);
    check("t3_ovf_sticky", bus.overflow, 1);

    // Pulse coinciding with REQ_LO->IDLE while pending=2.
    do_reset();
    bus.pulse_in = 1'b1;
    step(3);
    bus.pulse_in  = 1'b0;
    check("t4_pend2", bus.pending, 2);
    bus.ack_async = 1'b1;
    step(3);
    check("t4_req_lo", bus.req_out, 0);
    check("t4_busy_lo", bus.busy, 1);
    bus.ack_async = 1'b0;
    step(2);
    bus.pulse_in = 1'b1;
    step(1);
    bus.pulse_in = 1'b0;
    check("t4_idle", bus.busy, 0);
    check("t4_pend3", bus.pending, 3);
    step(1);
    check("t4_relaunch", bus.req_out, 1);
    check("t4_pend_end", bus.pending, 2);

    // Asynchronous reset mid-handshake with pending=3.
    do_reset();
    bus.pulse_in = 1'b1;
    step(4);
    bus.pulse_in = 1'b0;
    check("t5_pend3", bus.pending, 3);
    check("t5_req_pre", bus.req_out, 1);
    #2;
    nrst = 1'b0;
    #1;
    check("t5_async_req", bus.req_out, 0);
    check("t5_async_busy", bus.busy, 0);
    check("t5_async_pend", bus.pending, 0);
    step(2);
    nrst = 1'b1;
    step(1);
    check("t5_post_idle", bus.busy, 0);
    bus.pulse_in = 1'b1;
    step(1);
    bus.pulse_in = 1'b0;
    check("t5_post_req", bus.req_out, 1);
    check("t5_post_pend", bus.pending, 0);

    // Ack never rises: watchdog after 16 cycles in REQ_HI, or indefinite wait.
    do_reset();
    bus.pulse_in = 1'b1;
    step(1);
    bus.pulse_in = 1'b0;
    check("t6_req", bus.req_out, 1);
    step(15);
    check("t6_req_before", bus.req_out, 1);
    step(1);
`ifdef PULSE_TX_TIMEOUT_EN
    check("t6_tmo_req", bus.req_out, 0);
    check("t6_tmo_flag", bus.timeout, 1);
    check("t6_tmo_idle", bus.busy, 0);
    check("t6_tmo_pend", bus.pending, 0);
`else
    check("t6_req_hold", bus.req_out, 1);
    check("t6_no_tmo", bus.timeout, 0);
    step(50);
    check("t6_req_long", bus.req_out, 1);
    check("t6_busy_long", bus.busy, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pulse_handshake_tx.md
PULSE_HANDSHAKE_TX -- requirements
Module: pulse_handshake_tx

Interface
REQ-001 Parameter CNT_W, default 3: width of the pending-request counter.
REQ-002 Parameter TIMEOUT_CYC, default 255: cycles allowed per handshake phase (used only with PULSE_TX_TIMEOUT_EN).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 nrst  input  1  reset; asynchronous, active-low.
REQ-005 pulse_in  input  1  single-cycle transfer request, synchronous to clk (e.g. an edge-detector output).
REQ-006 ack_async  input  1  acknowledge from the far domain; asynchronous to clk.
REQ-007 req_out  output  1  four-phase request to the far domain; registered, glitch-free.
REQ-008 busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 pending  output  CNT_W  count of accepted requests not yet launched.
REQ-010 overflow  output  1  sticky; a pulse_in was dropped.
REQ-011 timeout  output  1  sticky; a handshake phase timed out (constant 0 when the feature is compiled out).

Function
REQ-012 ack_async SHALL pass through a 2-flop synchronizer before use; ack_s lags ack_async by 2 clk edges.
REQ-013 FSM states SHALL be IDLE, REQ_HI and REQ_LO.
REQ-014 IDLE: if pending>0 or pulse_in=1, go to REQ_HI next edge; req_out=1 from that edge.
REQ-015 REQ_HI: hold req_out=1; when ack_s=1, go to REQ_LO; req_out=0 from that edge.
REQ-016 REQ_LO: hold req_out=0; when ack_s=0, go to IDLE.
REQ-017 req_out SHALL equal (state==REQ_HI), registered; it changes only on state transitions.
REQ-018 Latency: pulse_in high in IDLE with pending=0 SHALL give req_out=1 on the next edge, with pending unchanged at 0.
REQ-019 Each IDLE->REQ_HI launch SHALL consume exactly one request, taken from pending first, otherwise from the concurrent pulse_in.
REQ-020 Any pulse_in not consumed by a launch SHALL increment pending.
REQ-021 Simultaneous launch and pulse_in with pending>0: pending unchanged (decrement and increment cancel).
REQ-022 pending SHALL saturate at 2^CNT_W-1; an unconsumed pulse_in at saturation is dropped and sets overflow.
REQ-023 overflow and timeout SHALL clear only on reset.
REQ-024 ack_s high while in IDLE SHALL be ignored; no state change results.
REQ-025 busy SHALL be combinational from the state register: (state!=IDLE).

Reset
REQ-026 nrst low SHALL immediately force: state=IDLE, req_out=0, busy=0, pending=0, overflow=0, timeout=0, synchronizer flops=0, timeout counter=0.
REQ-027 Reset mid-handshake SHALL abandon the transfer and discard all pending requests; req_out drops asynchronously.
REQ-028 On the first edge after release, behaviour SHALL be as from a fresh IDLE.

Configuration
REQ-029 Macro PULSE_TX_TIMEOUT_EN defined: a phase counter clears on entry to REQ_HI or REQ_LO and increments each cycle the state does not advance.
REQ-030 With the macro defined, the counter reaching TIMEOUT_CYC SHALL set timeout, force req_out=0 and return the FSM to IDLE; the transfer is dropped and pending is not restored.
REQ-031 With the macro defined, a timeout that coincides with the advance condition SHALL let the advance win.
REQ-032 Macro undefined: no counter logic is built, timeout is tied to 0, and the FSM waits indefinitely in each phase.

Verification
REQ-033 One pulse_in in IDLE, far end acks 3 cycles after req, releases 3 cycles after req falls -> req_out 1 at edge+1; back in IDLE with busy=0; pending stays 0.
REQ-034 Five pulses on consecutive cycles with ack stuck low -> pending=4 and req_out=1 after the burst; overflow=0.
REQ-035 CNT_W=3, ack stuck low, 9 pulses -> pending=7 after the first launch absorbs one pulse; extra pulse sets overflow=1.
REQ-036 pulse_in on the same edge as the REQ_LO->IDLE transition with pending=2 -> next launch consumes one, ending with pending=2.
REQ-037 nrst asserted while in REQ_HI with pending=3 -> req_out, busy and pending go 0 at once; first pulse after release launches normally.
REQ-038 PULSE_TX_TIMEOUT_EN, TIMEOUT_CYC=16, ack never rises -> after 16 cycles in REQ_HI: timeout=1, req_out=0, IDLE; without the macro, req_out stays 1 indefinitely.
